// File: rtl/crc16_pkg.sv
// -----------------------------------------------------------------------------
// crc16_pkg
// Shared constants, state encoding and the single-bit CRC update used by the
// multi-lane SD data-path CRC16 engine (x^16 + x^12 + x^5 + 1, zero init,
// MSB first).
// No ports (package).
// -----------------------------------------------------------------------------
package crc16_pkg;

  localparam int CRC_W = 16;

  localparam logic [CRC_W-1:0] POLY = 16'h1021;

  // The x^0 term lands on bit 0 through the shift itself, so only the
  // x^5 and x^12 taps need an explicit XOR.
  localparam logic [CRC_W-1:0] TAP_MASK = POLY & ~16'h0001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Advance a CRC register by one data bit (MSB-first LFSR step).
  function automatic logic [CRC_W-1:0] crc16_step(input logic [CRC_W-1:0] crc,
                                                   input logic             din);
    logic fb;
    fb = din ^ crc[CRC_W-1];
    return {crc[CRC_W-2:0], fb} ^ (fb ? TAP_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/crc16_lanes_if.sv
// -----------------------------------------------------------------------------
// crc16_lanes_if
// Control/data bundle between the DAT serialiser side and crc16_lanes.
// Signals:
//   istb      bit strobe                 istart   begin-block pulse
//   imode     0 = generate, 1 = check    idata    per-lane data / received CRC
//   obusy     block in progress          ocrc     per-lane CRC MSB
//   ocrc_vld  generated CRC on ocrc      odone    one-cycle end-of-block pulse
//   oerr      per-lane CRC mismatch
//   oerr_cnt  errored check-block count (only with CRC16_ERRCNT_EN defined)
// master: block driver side; slave: crc16_lanes.
// -----------------------------------------------------------------------------
interface crc16_lanes_if #(
  parameter int LANES = 4
);

  logic             istb;
  logic             istart;
  logic             imode;
  logic [LANES-1:0] idata;
  logic             obusy;
  logic [LANES-1:0] ocrc;
  logic             ocrc_vld;
  logic             odone;
  logic [LANES-1:0] oerr;
`ifdef CRC16_ERRCNT_EN
  logic [15:0]      oerr_cnt;

  modport master (
    output istb, istart, imode, idata,
    input  obusy, ocrc, ocrc_vld, odone, oerr, oerr_cnt
  );

  modport slave (
    input  istb, istart, imode, idata,
    output obusy, ocrc, ocrc_vld, odone, oerr, oerr_cnt
  );
`else
  modport master (
    output istb, istart, imode, idata,
    input  obusy, ocrc, ocrc_vld, odone, oerr
  );

  modport slave (
    input  istb, istart, imode, idata,
    output obusy, ocrc, ocrc_vld, odone, oerr
  );
`endif

endinterface

// File: rtl/crc16_lane.sv
// -----------------------------------------------------------------------------
// crc16_lane
// One DAT line's CRC16 register plus its sticky mismatch flag.
// Ports:
//   iclk, irst_n  clock, asynchronous active-low reset
//   iclr          clear CRC and error flag (block start)
//   iupd          consume idin through the LFSR (data phase)
//   ishf          shift the CRC out by one bit (CRC phase)
//   icmp          compare idin with the outgoing MSB while shifting
//   idin          lane data bit / received CRC bit
//   ocrc_msb      current crc[15]
//   oerr          sticky mismatch flag
// -----------------------------------------------------------------------------
module crc16_lane
  import crc16_pkg::*;
(
  input  logic iclk,
  input  logic irst_n,
  input  logic iclr,
  input  logic iupd,
  input  logic ishf,
  input  logic icmp,
  input  logic idin,
  output logic ocrc_msb,
  output logic oerr
);

  logic [CRC_W-1:0] crc_r;
  logic             err_r;

  // CRC register: clear, LFSR update in data phase, plain shift in CRC phase
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      crc_r <= {CRC_W{1'b0}};
    end else if (iclr) begin
      crc_r <= {CRC_W{1'b0}};
    end else if (iupd) begin
      crc_r <= crc16_step(crc_r, idin);
    end else if (ishf) begin
      crc_r <= {crc_r[CRC_W-2:0], 1'b0};
    end else begin
      crc_r <= crc_r;
    end
  end

  // Sticky error flag: the received bit is compared against the bit being
  // shifted out in the same strobe
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      err_r <= 1'b0;
    end else if (iclr) begin
      err_r <= 1'b0;
    end else if (ishf && icmp && (idin != crc_r[CRC_W-1])) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign ocrc_msb = crc_r[CRC_W-1];
  assign oerr     = err_r;

endmodule

// File: rtl/crc16_lanes.sv
// -----------------------------------------------------------------------------
// crc16_lanes
// Multi-lane CRC16 engine for the SD DAT path. Generate mode appends 16 CRC
// bits per lane after BLK_LEN data bits; check mode compares 16 received CRC
// bits per lane and flags per-lane mismatches. Everything advances on istb.
// Parameters: LANES (1/4/8), BLK_LEN (data bits per lane per block).
// Ports:
//   iclk    system clock
//   irst_n  asynchronous active-low reset
//   bus     crc16_lanes_if.slave (istb, istart, imode, idata, obusy, ocrc,
//           ocrc_vld, odone, oerr [, oerr_cnt])
// Build option: CRC16_ERRCNT_EN adds oerr_cnt, a saturating count of
// check-mode blocks that ended with any lane in error (reset-only clear).
// -----------------------------------------------------------------------------
module crc16_lanes
  import crc16_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int BLK_LEN = 1024
)
(
  input  logic          iclk,
  input  logic          irst_n,
  crc16_lanes_if.slave  bus
);

  localparam int CNTW = ($clog2(BLK_LEN) > 4) ? $clog2(BLK_LEN) : 4;
  localparam logic [CNTW-1:0] DATA_LAST = CNTW'(BLK_LEN - 1);
  localparam logic [CNTW-1:0] CRC_LAST  = CNTW'(CRC_W - 1);

  state_e           state_r, state_s;
  logic [CNTW-1:0]  cnt_r, cnt_s;
  logic             mode_r, mode_s;
  logic             clr_s, upd_s, shf_s, cmp_s;
  logic             obusy_r, ocrc_vld_r, odone_r;
  logic [LANES-1:0] crc_msb_s;
  logic [LANES-1:0] err_s;

  // Next-state, counter and lane-control decode; istart overrides everything
  // (including a coincident istb, which is dropped)
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    mode_s  = mode_r;
    clr_s   = 1'b0;
    upd_s   = 1'b0;
    shf_s   = 1'b0;
    cmp_s   = 1'b0;
    if (bus.istart) begin
      state_s = DATA;
      cnt_s   = {CNTW{1'b0}};
      mode_s  = bus.imode;
      clr_s   = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = IDLE;
        end
        DATA: begin
          if (bus.istb) begin
            upd_s = 1'b1;
            if (cnt_r == DATA_LAST) begin
              state_s = CRC;
              cnt_s   = {CNTW{1'b0}};
            end else begin
              cnt_s = cnt_r + CNTW'(1'b1);
            end
          end else begin
            cnt_s = cnt_r;
          end
        end
        CRC: begin
          if (bus.istb) begin
            shf_s = 1'b1;
            cmp_s = mode_r;
            if (cnt_r == CRC_LAST) begin
              state_s = DONE;
              cnt_s   = {CNTW{1'b0}};
            end else begin
              cnt_s = cnt_r + CNTW'(1'b1);
            end
          end else begin
            cnt_s = cnt_r;
          end
        end
        DONE: begin
          state_s = IDLE;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State, counter and mode registers
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CNTW{1'b0}};
      mode_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      mode_r  <= mode_s;
    end
  end

  // Status outputs registered from the next state so they line up with it
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      obusy_r    <= 1'b0;
      ocrc_vld_r <= 1'b0;
      odone_r    <= 1'b0;
    end else begin
      obusy_r    <= (state_s == DATA) || (state_s == CRC);
      ocrc_vld_r <= (state_s == CRC) && !mode_s;
      odone_r    <= (state_s == DONE);
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    crc16_lane u_lane (
      .iclk     (iclk),
      .irst_n   (irst_n),
      .iclr     (clr_s),
      .iupd     (upd_s),
      .ishf     (shf_s),
      .icmp     (cmp_s),
      .idin     (bus.idata[l]),
      .ocrc_msb (crc_msb_s[l]),
      .oerr     (err_s[l])
    );
  end

  assign bus.obusy    = obusy_r;
  assign bus.ocrc_vld = ocrc_vld_r;
  assign bus.odone    = odone_r;
  assign bus.ocrc     = crc_msb_s;
  assign bus.oerr     = err_s;

`ifdef CRC16_ERRCNT_EN
  logic [15:0] err_cnt_r;

  // Saturating count of errored check blocks, bumped as DONE is left
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      err_cnt_r <= 16'h0000;
    end else if ((state_r == DONE) && mode_r && (|err_s) && (err_cnt_r != 16'hFFFF)) begin
      err_cnt_r <= err_cnt_r + 16'h0001;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign bus.oerr_cnt = err_cnt_r;
`endif

endmodule

// File: tb/tb_crc16_lanes.sv
// -----------------------------------------------------------------------------
// tb_crc16_lanes
// Directed bench for crc16_lanes: a 1-lane/4096-bit instance for the known
// all-ones SD vector and a 4-lane/1024-bit instance for generate, check,
// abort and asynchronous-reset scenarios.
// -----------------------------------------------------------------------------
module tb_crc16_lanes;

  logic iclk = 1'b0;
  logic irst_n;

  always #5 iclk = ~iclk;

  crc16_lanes_if #(.LANES(1)) ifa ();
  crc16_lanes_if #(.LANES(4)) ifb ();

  crc16_lanes #(.LANES(1), .BLK_LEN(4096)) dut_a (
    .iclk   (iclk),
    .irst_n (irst_n),
    .bus    (ifa.slave)
  );

  crc16_lanes #(.LANES(4), .BLK_LEN(1024)) dut_b (
    .iclk   (iclk),
    .irst_n (irst_n),
    .bus    (ifb.slave)
  );

  int          tests_run;
  int          tests_failed;
  logic [3:0]  blk_data [1024];
  logic [15:0] model    [4];
  logic [15:0] got_b    [4];
  int          vld_cnt;

  // Textbook serial CRC-16 (poly 0x1021, MSB first)
  function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic d);
    logic [15:0] r;
    r = {c[14:0], 1'b0};
    if (c[15] ^ d) r = r ^ 16'h1021;
    return r;
  endfunction

  task automatic step;
    @(posedge iclk);
    #1;
  endtask

  task automatic calc_model;
    for (int l = 0; l < 4; l++) begin
      model[l] = 16'h0000;
      for (int i = 0; i < 1024; i++) model[l] = crc_bit(model[l], blk_data[i][l]);
    end
  endtask

  task automatic start_b(input logic mode);
    ifb.imode  = mode;
    ifb.istart = 1'b1;
    ifb.istb   = 1'b0;
    step();
    ifb.istart = 1'b0;
    ifb.imode  = 1'b0;
  endtask

  task automatic data_b(input int gap);
    for (int i = 0; i < 1024; i++) begin
      ifb.istb = 1'b0;
      repeat (gap) step();
      ifb.idata = blk_data[i];
      ifb.istb  = 1'b1;
      step();
    end
    ifb.istb = 1'b0;
  endtask

  // Sample ocrc just before each of 16 strobes
  task automatic collect_b(input int gap);
    vld_cnt = 0;
    for (int l = 0; l < 4; l++) got_b[l] = 16'h0000;
    for (int k = 0; k < 16; k++) begin
      ifb.istb = 1'b0;
      repeat (gap) step();
      for (int l = 0; l < 4; l++) got_b[l][15-k] = ifb.ocrc[l];
      if (ifb.ocrc_vld === 1'b1) vld_cnt++;
      ifb.istb = 1'b1;
      step();
    end
    ifb.istb = 1'b0;
  endtask

  task automatic run_check_b(input logic flip);
    logic [3:0] v;
    start_b(1'b1);
    data_b(0);
    vld_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      for (int l = 0; l < 4; l++) v[l] = model[l][15-k];
      if (flip && (k == 8)) v[2] = ~v[2];
      if (ifb.ocrc_vld === 1'b1) vld_cnt++;
      ifb.idata = v;
      ifb.istb  = 1'b1;
      step();
    end
    ifb.istb = 1'b0;
  endtask

  task automatic test_reset;
    irst_n = 1'b0;
    ifa.istb = 1'b0; ifa.istart = 1'b0; ifa.imode = 1'b0; ifa.idata = 1'b0;
    ifb.istb = 1'b0; ifb.istart = 1'b0; ifb.imode = 1'b0; ifb.idata = 4'h0;
    #12;
    tests_run++;
    if ({ifa.obusy, ifa.ocrc_vld, ifa.odone, ifa.oerr, ifa.ocrc} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_a: got %b expected 00000",
               {ifa.obusy, ifa.ocrc_vld, ifa.odone, ifa.oerr, ifa.ocrc});
    end
    tests_run++;
    if ({ifb.obusy, ifb.ocrc_vld, ifb.odone, ifb.oerr, ifb.ocrc} !== 11'b0) begin
      tests_failed++;
      $display("FAIL reset_b: got %b expected 0", {ifb.obusy, ifb.ocrc_vld, ifb.odone, ifb.oerr, ifb.ocrc});
    end
`ifdef CRC16_ERRCNT_EN
    tests_run++;
    if (ifb.oerr_cnt !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_errcnt: got %h expected 0000", ifb.oerr_cnt);
    end
`endif
    @(negedge iclk);
    irst_n = 1'b1;
    step();
  endtask

  task automatic test_ones_1lane;
    logic [15:0] got;
    logic        vld_ok;
    ifa.imode  = 1'b0;
    ifa.istart = 1'b1;
    ifa.istb   = 1'b0;
    step();
    ifa.istart = 1'b0;
    tests_run++;
    if (ifa.obusy !== 1'b1) begin
      tests_failed++;
      $display("FAIL ones_busy: got %b expected 1", ifa.obusy);
    end
    ifa.idata = 1'b1;
    ifa.istb  = 1'b1;
    repeat (4096) step();
    vld_ok = 1'b1;
    got    = 16'h0000;
    for (int k = 0; k < 16; k++) begin
      got[15-k] = ifa.ocrc[0];
      if (ifa.ocrc_vld !== 1'b1) vld_ok = 1'b0;
      step();
    end
    ifa.istb = 1'b0;
    tests_run++;
    if (got !== 16'h7FA1) begin
      tests_failed++;
      $display("FAIL ones_crc: got %h expected 7fa1", got);
    end
    tests_run++;
    if (vld_ok !== 1'b1) begin
      tests_failed++;
      $display("FAIL ones_vld: got %b expected 1", vld_ok);
    end
    tests_run++;
    if ({ifa.odone, ifa.oerr} !== 2'b10) begin
      tests_failed++;
      $display("FAIL ones_done: got odone/oerr %b expected 10", {ifa.odone, ifa.oerr});
    end
    step();
    tests_run++;
    if ({ifa.odone, ifa.obusy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL ones_idle: got odone/obusy %b expected 00", {ifa.odone, ifa.obusy});
    end
  endtask

  task automatic test_gen_random;
    for (int i = 0; i < 1024; i++) blk_data[i] = 4'($urandom);
    calc_model();
    start_b(1'b0);
    data_b(2);
    collect_b(2);
    for (int l = 0; l < 4; l++) begin
      tests_run++;
      if (got_b[l] !== model[l]) begin
        tests_failed++;
        $display("FAIL gen_lane%0d: got %h expected %h", l, got_b[l], model[l]);
      end
    end
    tests_run++;
    if (ifb.odone !== 1'b1) begin
      tests_failed++;
      $display("FAIL gen_done: got %b expected 1", ifb.odone);
    end
    step();
    tests_run++;
    if ((vld_cnt != 16) || (ifb.ocrc_vld !== 1'b0)) begin
      tests_failed++;
      $display("FAIL gen_vld: got count %0d vld %b expected 16 0", vld_cnt, ifb.ocrc_vld);
    end
  endtask

  task automatic test_check_ok;
    run_check_b(1'b0);
    tests_run++;
    if ({ifb.odone, ifb.oerr, vld_cnt[4:0]} !== {1'b1, 4'b0000, 5'd0}) begin
      tests_failed++;
      $display("FAIL chk_ok: got odone %b oerr %b vld %0d expected 1 0000 0",
               ifb.odone, ifb.oerr, vld_cnt);
    end
    step();
  endtask

  task automatic test_check_err;
    run_check_b(1'b1);
    tests_run++;
    if ({ifb.odone, ifb.oerr} !== 5'b10100) begin
      tests_failed++;
      $display("FAIL chk_err: got odone %b oerr %b expected 1 0100", ifb.odone, ifb.oerr);
    end
`ifdef CRC16_ERRCNT_EN
    tests_run++;
    if (ifb.oerr_cnt !== 16'h0000) begin
      tests_failed++;
      $display("FAIL errcnt_before: got %h expected 0000", ifb.oerr_cnt);
    end
`endif
    step();
    tests_run++;
    if (ifb.oerr !== 4'b0100) begin
      tests_failed++;
      $display("FAIL chk_err_hold: got %b expected 0100", ifb.oerr);
    end
`ifdef CRC16_ERRCNT_EN
    tests_run++;
    if (ifb.oerr_cnt !== 16'h0001) begin
      tests_failed++;
      $display("FAIL errcnt_after: got %h expected 0001", ifb.oerr_cnt);
    end
`endif
  endtask

  task automatic test_abort;
    start_b(1'b0);
    for (int i = 0; i < 300; i++) begin
      ifb.idata = 4'($urandom);
      ifb.istb  = 1'b1;
      step();
    end
    start_b(1'b0);
    tests_run++;
    if ({ifb.obusy, ifb.odone, ifb.oerr} !== 6'b100000) begin
      tests_failed++;
      $display("FAIL abort_restart: got busy/done/err %b expected 100000",
               {ifb.obusy, ifb.odone, ifb.oerr});
    end
    for (int i = 0; i < 1024; i++) blk_data[i] = 4'hF;
    calc_model();
    data_b(0);
    collect_b(0);
    tests_run++;
    if ({got_b[0], got_b[1], got_b[2], got_b[3]} !== {model[0], model[1], model[2], model[3]}) begin
      tests_failed++;
      $display("FAIL abort_crc: got %h %h %h %h expected %h",
               got_b[0], got_b[1], got_b[2], got_b[3], model[0]);
    end
    tests_run++;
    if (ifb.odone !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_done: got %b expected 1", ifb.odone);
    end
    step();
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 1024; i++) blk_data[i] = 4'($urandom);
    start_b(1'b0);
    data_b(0);
    ifb.istb = 1'b1;
    repeat (5) step();
    ifb.istb = 1'b0;
    #2;
    irst_n = 1'b0;
    #1;
    tests_run++;
    if ({ifb.obusy, ifb.ocrc_vld, ifb.odone, ifb.oerr, ifb.ocrc} !== 11'b0) begin
      tests_failed++;
      $display("FAIL async_rst: got %b expected 0", {ifb.obusy, ifb.ocrc_vld, ifb.odone, ifb.oerr, ifb.ocrc});
    end
    @(negedge iclk);
    irst_n = 1'b1;
    step();
    for (int i = 0; i < 1024; i++) blk_data[i] = 4'($urandom);
    calc_model();
    // Strobe coincident with istart carries a stray bit that must be dropped
    ifb.imode  = 1'b0;
    ifb.istart = 1'b1;
    ifb.istb   = 1'b1;
    ifb.idata  = ~blk_data[0];
    step();
    ifb.istart = 1'b0;
    for (int i = 0; i < 1023; i++) begin
      ifb.idata = blk_data[i];
      step();
    end
    tests_run++;
    if ({ifb.obusy, ifb.ocrc_vld} !== 2'b10) begin
      tests_failed++;
      $display("FAIL stb_start_1023: got busy/vld %b expected 10", {ifb.obusy, ifb.ocrc_vld});
    end
    ifb.idata = blk_data[1023];
    step();
    ifb.istb = 1'b0;
    tests_run++;
    if (ifb.ocrc_vld !== 1'b1) begin
      tests_failed++;
      $display("FAIL stb_start_1024: got vld %b expected 1", ifb.ocrc_vld);
    end
    collect_b(0);
    for (int l = 0; l < 4; l++) begin
      tests_run++;
      if (got_b[l] !== model[l]) begin
        tests_failed++;
        $display("FAIL stb_start_lane%0d: got %h expected %h", l, got_b[l], model[l]);
      end
    end
    step();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_ones_1lane();
    test_gen_random();
    test_check_ok();
    test_check_err();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/crc16_lanes.md
Name: crc16_lanes

Overview:
Parametrised multi-lane CRC16 engine for the SD data path. It uses the polynomial x^16+x^12+x^5+1, zero init and MSB-first order.
- LANES independent CRC registers, one per DAT line, advanced on a bit strobe.
- Generate mode: appends 16 CRC bits per lane after a block of BLK_LEN data bits.
- Check mode: compares the 16 received CRC bits per lane and reports per-lane errors.
- Sits between the d_driver serialiser/deserialiser and the DAT pads.

Parameters:
LANES, 4, number of DAT lines (1, 4 or 8).
BLK_LEN, 1024, data bits per lane per block (>=1); 512-byte block on 4 lanes.
CNTW, $clog2(BLK_LEN)>4 ? $clog2(BLK_LEN) : 4, counter width (derived, not overridden).

Ports:
iclk  in  1  system clock
irst_n  in  1  asynchronous active-low reset
istb  in  1  bit strobe; all CRC/counter advances qualified by istb
istart  in  1  one-cycle pulse: begin block, latch imode, clear CRCs and oerr
imode  in  1  0 = generate (TX), 1 = check (RX); sampled only with istart
idata  in  LANES  per-lane data bit (DATA state), received CRC bit (check CRC state)
obusy  out  1  high in DATA and CRC states
ocrc  out  LANES  per-lane current CRC MSB (crc[l][15]), registered
ocrc_vld  out  1  high in CRC state when generating
odone  out  1  one iclk pulse at block end
oerr  out  LANES  per-lane CRC mismatch, valid from odone until next istart/reset

Behaviour:
- Reset (irst_n low, async):
  - State IDLE, all CRC registers and the counter 0.
  - Mode 0.
  - obusy, ocrc_vld, odone, oerr, ocrc all 0.
- States: IDLE, DATA, CRC, DONE.
- istart (any state, highest priority):
  - Next cycle enters DATA, cnt=0, CRCs=0, oerr=0, mode=imode.
  - An istb in the same cycle is ignored (bit not consumed).
  - istart mid-block aborts silently; no odone.
- DATA, per istb:
  - Each lane: fb = idata[l]^crc[15]; crc <= {crc[14:0],fb} ^ (fb ? 16'h1020 : 0), i.e. taps at bits 5 and 12.
  - cnt++.
  - On the istb with cnt==BLK_LEN-1: go to CRC with cnt=0.
- CRC, per istb:
  - ocrc presents crc[15] before the strobe.
  - On istb: crc <= {crc[14:0],1'b0} (pure shift, no feedback).
  - Check mode: if idata[l] != crc[l][15], set oerr[l] (sticky).
  - On the 16th istb (cnt==15): go to DONE.
- DONE: odone=1 for exactly one iclk, then IDLE. oerr holds.
- Without istb the block stalls in any state; outputs hold.
- ocrc_vld = (state==CRC) & ~mode. ocrc is driven in check mode too but ignored.
- Latency: istart -> obusy high next cycle. The last CRC istb -> odone the following cycle.
- Counter never wraps past BLK_LEN-1 in DATA or past 15 in CRC.

Optional Feature:
CRC16_ERRCNT_EN
- Defined:
  - Adds output oerr_cnt[15:0], a saturating count of check-mode blocks with any oerr bit set.
  - Increments in the DONE cycle; holds at 16'hFFFF.
  - Cleared only by irst_n.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package crc16_pkg:
  - CRC_W=16
  - POLY=16'h1021
  - Feedback tap mask 16'h1020
  - State enum {IDLE, DATA, CRC, DONE}
- Sub-module crc16_lane: one lane register with ports for clear, update-with-feedback, shift-out and compare-bit → err. Instantiated LANES times via generate; the FSM and counter stay in crc16_lanes.

Test Plan:
- LANES=1, BLK_LEN=4096, gen mode, 4096 ones with istb every cycle -> 16 ocrc bits equal 16'h7FA1 MSB first; then odone one cycle; oerr=0.
- LANES=4, BLK_LEN=1024, gen mode, random data, istb every 3rd cycle -> each lane's ocrc stream matches the bitwise model; ocrc_vld high for exactly 16 strobes.
- LANES=4, check mode, random data, then correct CRCs -> odone, oerr=4'b0000.
- Same as previous with CRC bit 7 of lane 2 flipped -> oerr=4'b0100; with CRC_ERRCNT_EN, oerr_cnt increments 0->1.
- istart asserted after 300 data bits, then a full block of ones -> no odone from the aborted block; result identical to a clean run.
- irst_n dropped asynchronously mid-CRC state -> all outputs 0 immediately; istart with istb in the same cycle -> that bit not counted (block needs BLK_LEN further strobes).
